alu_shift_seq: RTL

Iterative shift/rotate sequencer for the ALU. It accepts one shift or rotate request per handshake and performs it one bit position per clock in an internal 32-bit accumulator. It serves SHR, SHRA, SHL, ROR and ROL for the control unit where a single-cycle barrel network is not wanted. The control unit waits on `done`, then latches `data_out` into the Z register.

---
 rtl/alu_shift_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/alu_shift_seq.sv
// Iterative shift/rotate sequencer: one bit position per clock on a 32-bit accumulator.
// Ports: clk, clr (sync active-high reset), start/op/data_in/amount request, busy/done/data_out status.
module alu_shift_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] data_in,
    input  logic [4:0]  amount,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out
);

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  opr_q, opr_d;

    logic        in_reserved;
    logic        is_shr, is_shra, is_shl, is_ror, is_rol;
    logic [31:0] step;

    // Reserved requests are treated as zero-length: data passes through untouched.
    assign in_reserved = (op > OP_ROL);

    assign is_shr  = (opr_q == OP_SHR);
    assign is_shra = (opr_q == OP_SHRA);
    assign is_shl  = (opr_q == OP_SHL);
    assign is_ror  = (opr_q == OP_ROR);
    assign is_rol  = (opr_q == OP_ROL);

    // One-bit step of the latched operation.
    always_comb begin
        step = acc_q;
        unique case (1'b1)
            is_shr:  step = {1'b0, acc_q[31:1]};
            is_shra: step = {acc_q[31], acc_q[31:1]};
            is_shl:  step = {acc_q[30:0], 1'b0};
            is_ror:  step = {acc_q[0], acc_q[31:1]};
            is_rol:  step = {acc_q[30:0], acc_q[31]};
            default: step = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        opr_d   = opr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = data_in;
                    cnt_d = amount;
                    opr_d = op;
                    if ((amount == 5'd0) || in_reserved) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // clr wins over any pending request and abandons a run without a done pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            acc_q   <= 32'd0;
            cnt_q   <= 5'd0;
            opr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            opr_q   <= opr_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign data_out = acc_q;

endmodule
